// File: rtl/sport_ram.sv
// sport_ram: single-port synchronous RAM with registered write-through read data.
// Define SPORT_RAM_PARITY_EN to add a per-word even-parity bit and the parity_err output.
module sport_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wenable,
  input  logic [DATA_WIDTH-1:0] data_in,
`ifdef SPORT_RAM_PARITY_EN
  output logic                  parity_err,
`endif
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  // An unknown wenable falls through to the read branch, so mem is never written.
  always_comb begin
    data_d = mem_q[addr];
    if (wenable) data_d = data_in;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_q <= '0;
    end else begin
      if (wenable) mem_q[addr] <= data_in;
      data_q <= data_d;
    end
  end
  assign data_out = data_q;
`ifdef SPORT_RAM_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             err_q, err_d;
  always_comb begin
    err_d = (^mem_q[addr]) ^ par_q[addr];
    if (wenable) err_d = 1'b0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      par_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (wenable) par_q[addr] <= ^data_in;
      err_q <= err_d;
    end
  end
  assign parity_err = err_q;
`endif
endmodule

// File: tb/tb_sport_ram.sv
// tb_sport_ram: randomized self-checking bench for sport_ram against an array model.
module tb_sport_ram;
  logic        clock = 1'b1;
  logic        reset;
  logic [2:0]  addr;
  logic        wenable;
  logic [31:0] data_in;
  logic [31:0] data_out;
`ifdef SPORT_RAM_PARITY_EN
  logic        parity_err;
  logic        exp_pe;
  logic [7:0]  pflip;
`endif
  logic [31:0] m [8];
  logic [31:0] exp_q;
  int tests = 0;
  int fails = 0;

  sport_ram dut (
    .clock(clock), .reset(reset), .addr(addr), .wenable(wenable),
    .data_in(data_in),
`ifdef SPORT_RAM_PARITY_EN
    .parity_err(parity_err),
`endif
    .data_out(data_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask

  always @(negedge reset) begin
    for (int i = 0; i < 8; i++) m[i] = '0;
    exp_q = '0;
`ifdef SPORT_RAM_PARITY_EN
    exp_pe = 1'b0;
    pflip = '0;
`endif
  end

  // model update at every active edge, compare 1 ns later
  always @(posedge clock) begin
    if (reset === 1'b1) begin
      if (wenable === 1'b1) begin
        m[addr] = data_in;
        exp_q = data_in;
`ifdef SPORT_RAM_PARITY_EN
        exp_pe = 1'b0;
        pflip[addr] = 1'b0;
`endif
      end else begin
        exp_q = m[addr];
`ifdef SPORT_RAM_PARITY_EN
        exp_pe = pflip[addr];
`endif
      end
    end
    #1;
    chk("cycle_data", data_out, exp_q);
`ifdef SPORT_RAM_PARITY_EN
    chk("cycle_perr", {31'b0, parity_err}, {31'b0, exp_pe});
`endif
  end

  task automatic step(input logic we, input logic [2:0] a, input logic [31:0] d);
    wenable = we;
    addr = a;
    data_in = d;
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m[i] = '0;
    exp_q = '0;
`ifdef SPORT_RAM_PARITY_EN
    exp_pe = 1'b0;
    pflip = '0;
`endif
    reset = 1'b0; wenable = 1'b0; addr = '0; data_in = '0;
    #15;
    chk("reset_hold", data_out, 32'd0);
    reset = 1'b1;
    step(1'b0, 3'd5, 32'd0);        chk("cleared_read", data_out, 32'd0);
    step(1'b1, 3'd3, 32'd52);       chk("write3", data_out, 32'd52);
    step(1'b0, 3'd3, 32'd0);        chk("read3", data_out, 32'd52);
    step(1'b1, 3'd4, 32'd100);      chk("write4", data_out, 32'd100);
    step(1'b0, 3'd4, 32'd0);        chk("read4", data_out, 32'd100);
    step(1'b0, 3'd3, 32'd0);        chk("no_alias3", data_out, 32'd52);
    step(1'b1, 3'd7, 32'hFFFFFFFF); chk("write7", data_out, 32'hFFFFFFFF);
    #2 reset = 1'b0;
    #1 chk("async_clear", data_out, 32'd0);
    wenable = 1'b0; addr = 3'd7;
    #1 reset = 1'b1;
    @(negedge clock);               chk("read7_after_rst", data_out, 32'd0);
    step(1'b0, 3'd3, 32'd0);        chk("read3_after_rst", data_out, 32'd0);
    step(1'b1, 3'd0, 32'h1234);     chk("write_after_rel", data_out, 32'h1234);
`ifdef SPORT_RAM_PARITY_EN
    step(1'b1, 3'd2, 32'hA5A5A5A5); chk("perr_on_write", {31'b0, parity_err}, 32'd0);
    force dut.par_q[2] = 1'b1;
    pflip[2] = 1'b1;
    step(1'b0, 3'd2, 32'd0);
    chk("perr_flip", {31'b0, parity_err}, 32'd1);
    chk("perr_data", data_out, 32'hA5A5A5A5);
    release dut.par_q[2];
    step(1'b0, 3'd1, 32'd0);        chk("perr_clean", {31'b0, parity_err}, 32'd0);
`endif
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        wenable = 1'($urandom_range(0, 1));
        addr = 3'($urandom_range(0, 7));
        data_in = $urandom;
        #2 reset = 1'b0;
        #1 chk("rand_async_clear", data_out, 32'd0);
        #1 reset = 1'b1;
        @(negedge clock);
      end else begin
        step(1'($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), $urandom);
      end
    end
    for (int a = 0; a < 8; a++) begin
      step(1'b0, 3'(a), 32'd0);
      chk("final_sweep", data_out, m[a]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
